// File: rtl/vrgi_pkg.sv
// Shared types and helpers for the vector register group issue stage:
// op record, reserved vlmul code, legality check and beat count.
package vrgi_pkg;

  localparam int VREG_W = 5;
  localparam int TAG_W  = 4;

  localparam logic [2:0] VLMUL_RSVD = 3'b100;

  typedef struct packed {
    logic [VREG_W-1:0] vreg;
    logic [2:0]        vlmul;
    logic [TAG_W-1:0]  tag;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BEATS
  } state_t;

  // Integer LMUL groups must start on a register number that is a multiple of LMUL.
  function automatic logic is_legal(op_t op);
    logic [VREG_W-1:0] mask;
    if (op.vlmul == VLMUL_RSVD) return 1'b0;
    if (op.vlmul[2]) return 1'b1;
    mask = VREG_W'((32'd1 << op.vlmul) - 32'd1);
    return (op.vreg & mask) == '0;
  endfunction

  function automatic logic [3:0] beats(logic [2:0] vlmul);
    return vlmul[2] ? 4'd1 : 4'(4'd1 << vlmul[1:0]);
  endfunction

  function automatic logic [VREG_W-1:0] group_idx(op_t op);
    return op.vlmul[2] ? op.vreg : (op.vreg >> op.vlmul[1:0]);
  endfunction

endpackage

// File: rtl/vrgi_fifo.sv
// Small op FIFO: power-of-two depth, wrapping pointers plus an occupancy count.
// Flush empties it and overrides any push or pop in the same cycle.
module vrgi_fifo
  import vrgi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  op_t  push_op,
  input  logic pop,
  output op_t  head,
  output logic empty,
  output logic full,
  output logic nonempty_nxt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  op_t           mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  assign head  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign nonempty_nxt = (count_d != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_op;
  end

endmodule

// File: rtl/vreg_group_issue.sv
// Feeds the vector register address generator: queues ops, drops misaligned ones,
// fires a one-cycle start and tags each generated beat with its op.
module vreg_group_issue
  import vrgi_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_vreg,
  input  logic [2:0]            in_vlmul,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  input  logic                  agu_idle,
  output logic                  agu_en,
  output logic [ADDR_WIDTH-1:0] agu_addr,
  output logic [2:0]            agu_vlmul,
  output logic                  beat_valid,
  output logic                  beat_last,
  output logic [TAG_WIDTH-1:0]  beat_tag,
  output logic                  err_valid,
  output logic [TAG_WIDTH-1:0]  err_tag
);

  op_t                  in_op, head;
  state_t               state_q, state_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 fifo_empty, fifo_full, fifo_nonempty_nxt;
  logic                 pop, head_legal;

  assign in_op      = '{vreg: in_vreg, vlmul: in_vlmul, tag: in_tag};
  assign in_ready   = ~fifo_full;
  assign head_legal = is_legal(head);

  vrgi_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (in_valid & in_ready),
    .push_op      (in_op),
    .pop          (pop),
    .head         (head),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .nonempty_nxt (fifo_nonempty_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    tag_d      = tag_q;
    if (flush) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (fifo_empty) begin
            state_d = ST_IDLE;
          end else if (!head_legal) begin
            state_d = fifo_nonempty_nxt ? ST_ISSUE : ST_IDLE;
          end else if (agu_idle) begin
            state_d    = ST_BEATS;
            beat_cnt_d = beats(head.vlmul);
            tag_d      = head.tag;
          end
        end
        ST_BEATS: begin
          beat_cnt_d = beat_cnt_q - 4'd1;
          if (beat_cnt_q == 4'd1) state_d = fifo_nonempty_nxt ? ST_ISSUE : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flush squashes every strobe in its own cycle.
  always_comb begin
    pop        = 1'b0;
    agu_en     = 1'b0;
    err_valid  = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_ISSUE: begin
          if (!fifo_empty) begin
            if (!head_legal) begin
              pop       = 1'b1;
              err_valid = 1'b1;
            end else if (agu_idle) begin
              pop    = 1'b1;
              agu_en = 1'b1;
            end
          end
        end
        ST_BEATS: begin
          beat_valid = 1'b1;
          beat_last  = (beat_cnt_q == 4'd1);
        end
        default: ;
      endcase
    end
  end

  assign agu_addr  = agu_en ? ADDR_WIDTH'(group_idx(head)) : '0;
  assign agu_vlmul = agu_en ? head.vlmul : 3'd0;
  assign beat_tag  = beat_valid ? tag_q : '0;
  assign err_tag   = err_valid ? head.tag : '0;

endmodule

// File: tb/tb_vreg_group_issue.sv
// Bench for vreg_group_issue: directed table, multi-cycle corner sequences,
// and a random run checked against an op-level scoreboard.
module tb_vreg_group_issue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_vreg = '0;
  logic [2:0] in_vlmul = '0;
  logic [3:0] in_tag = '0;
  logic       flush = 1'b0;
  logic       agu_idle = 1'b0;
  logic       agu_en;
  logic [4:0] agu_addr;
  logic [2:0] agu_vlmul;
  logic       beat_valid, beat_last;
  logic [3:0] beat_tag;
  logic       err_valid;
  logic [3:0] err_tag;

  vreg_group_issue #(.ADDR_WIDTH(5), .DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vreg(in_vreg), .in_vlmul(in_vlmul), .in_tag(in_tag), .flush(flush),
    .agu_idle(agu_idle), .agu_en(agu_en), .agu_addr(agu_addr), .agu_vlmul(agu_vlmul),
    .beat_valid(beat_valid), .beat_last(beat_last), .beat_tag(beat_tag),
    .err_valid(err_valid), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference rules on plain integers
  typedef struct { int vreg; int vlmul; int tag; } mop_t;

  function automatic int m_legal(mop_t m);
    if (m.vlmul == 4) return 0;
    if (m.vlmul < 4) return (m.vreg % (1 << m.vlmul)) == 0;
    return 1;
  endfunction
  function automatic int m_addr(mop_t m);
    return (m.vlmul < 4) ? m.vreg / (1 << m.vlmul) : m.vreg;
  endfunction
  function automatic int m_beats(mop_t m);
    return (m.vlmul < 4) ? (1 << m.vlmul) : 1;
  endfunction

  // Event logs and scoreboard, sampled on the falling edge
  int   en_addr_q[$], en_vlmul_q[$], en_cyc_q[$], last_tag_q[$], last_pos_q[$], err_tag_q[$];
  int   beat_seen = 0;
  int   run_len = 0;
  bit   sb_on = 1'b0;
  mop_t exp_q[$];
  int   pend = 0;
  int   ptag = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (beat_valid) begin
        beat_seen++;
        run_len++;
        if (beat_last) begin
          last_tag_q.push_back(int'(beat_tag));
          last_pos_q.push_back(run_len);
        end
      end
      if (agu_en) begin
        en_addr_q.push_back(int'(agu_addr));
        en_vlmul_q.push_back(int'(agu_vlmul));
        en_cyc_q.push_back(cyc);
        run_len = 0;
      end
      if (err_valid) err_tag_q.push_back(int'(err_tag));
      if (sb_on) begin
        mop_t m;
        if (beat_valid) begin
          chk("sb_beat_pending", int'(pend > 0), 1);
          if (pend > 0) begin
            chk("sb_beat_tag", int'(beat_tag), ptag);
            chk("sb_beat_last", int'(beat_last), int'(pend == 1));
            pend--;
          end
        end
        if (agu_en) begin
          chk("sb_en_idle", int'(agu_idle), 1);
          chk("sb_en_busy", pend, 0);
          chk("sb_en_queued", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("sb_en_legal", m_legal(m), 1);
            chk("sb_en_addr", int'(agu_addr), m_addr(m));
            chk("sb_en_vlmul", int'(agu_vlmul), m.vlmul);
            pend = m_beats(m);
            ptag = m.tag;
          end
        end
        if (err_valid) begin
          chk("sb_err_queued", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("sb_err_illegal", m_legal(m), 0);
            chk("sb_err_tag", int'(err_tag), m.tag);
          end
        end
        if (in_valid && in_ready && !flush)
          exp_q.push_back(mop_t'{int'(in_vreg), int'(in_vlmul), int'(in_tag)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    en_addr_q.delete(); en_vlmul_q.delete(); en_cyc_q.delete();
    last_tag_q.delete(); last_pos_q.delete(); err_tag_q.delete();
    beat_seen = 0;
  endtask

  task automatic push_op(int v, int l, int t);
    in_valid = 1'b1;
    in_vreg  = 5'(v);
    in_vlmul = 3'(l);
    in_tag   = 4'(t);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_beat(string name);
    int k = 0;
    while (!beat_valid && k < 30) begin
      step();
      k++;
    end
    chk(name, int'(beat_valid), 1);
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, "_in_ready"}, int'(in_ready), 1);
    chk({name, "_agu_en"}, int'(agu_en), 0);
    chk({name, "_agu_addr"}, int'(agu_addr), 0);
    chk({name, "_agu_vlmul"}, int'(agu_vlmul), 0);
    chk({name, "_beat_valid"}, int'(beat_valid), 0);
    chk({name, "_beat_last"}, int'(beat_last), 0);
    chk({name, "_beat_tag"}, int'(beat_tag), 0);
    chk({name, "_err_valid"}, int'(err_valid), 0);
    chk({name, "_err_tag"}, int'(err_tag), 0);
  endtask

  typedef struct {
    int vreg; int vlmul; int tag; int legal; int addr; int n;
  } vec_t;

  vec_t tbl[8];
  int   exp3[5];

  initial begin
    tbl[0] = '{8,  3, 1,  1, 1,  8};
    tbl[1] = '{6,  2, 2,  0, 0,  0};
    tbl[2] = '{6,  4, 2,  0, 0,  0};
    tbl[3] = '{12, 2, 6,  1, 3,  4};
    tbl[4] = '{5,  1, 7,  0, 0,  0};
    tbl[5] = '{31, 6, 8,  1, 31, 1};
    tbl[6] = '{10, 1, 9,  1, 5,  2};
    tbl[7] = '{17, 0, 10, 1, 17, 1};
    exp3   = '{0, 1, 2, 3, 9};

    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    run(2);
    rst = 1'b0;

    // Directed table: one op at a time, generator idle
    agu_idle = 1'b1;
    foreach (tbl[i]) begin
      clear_logs();
      push_op(tbl[i].vreg, tbl[i].vlmul, tbl[i].tag);
      run(14);
      chk($sformatf("v%0d_en_cnt", i), en_addr_q.size(), tbl[i].legal);
      chk($sformatf("v%0d_err_cnt", i), err_tag_q.size(), 1 - tbl[i].legal);
      chk($sformatf("v%0d_beats", i), beat_seen, tbl[i].n);
      if (en_addr_q.size() == 1) begin
        chk($sformatf("v%0d_addr", i), en_addr_q[0], tbl[i].addr);
        chk($sformatf("v%0d_vlmul", i), en_vlmul_q[0], tbl[i].vlmul);
      end
      if (last_pos_q.size() == 1) begin
        chk($sformatf("v%0d_last_pos", i), last_pos_q[0], tbl[i].n);
        chk($sformatf("v%0d_last_tag", i), last_tag_q[0], tbl[i].tag);
      end
      if (err_tag_q.size() == 1) chk($sformatf("v%0d_err_tag", i), err_tag_q[0], tbl[i].tag);
      chk($sformatf("v%0d_drained", i), int'(in_ready), 1);
    end

    // FIFO fill with generator busy, then in-order drain
    agu_idle = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) push_op(i, 0, i);
    chk("fill_in_ready_low", int'(in_ready), 0);
    in_valid = 1'b1; in_vreg = 5'd4; in_vlmul = 3'd0; in_tag = 4'd9;
    run(3);
    chk("fill_held_ready", int'(in_ready), 0);
    chk("fill_no_en", en_addr_q.size(), 0);
    agu_idle = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bit acc;
      acc = in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("fill_order_cnt", last_tag_q.size(), 5);
    if (last_tag_q.size() == 5)
      for (int j = 0; j < 5; j++) chk($sformatf("fill_order_%0d", j), last_tag_q[j], exp3[j]);

    // Two single-beat ops issue two cycles apart
    clear_logs();
    push_op(3, 7, 3);
    push_op(0, 0, 4);
    run(10);
    chk("b2b_last_cnt", last_tag_q.size(), 2);
    if (last_tag_q.size() == 2) begin
      chk("b2b_tag0", last_tag_q[0], 3);
      chk("b2b_tag1", last_tag_q[1], 4);
    end
    chk("b2b_en_cnt", en_cyc_q.size(), 2);
    if (en_cyc_q.size() == 2) chk("b2b_en_gap", en_cyc_q[1] - en_cyc_q[0], 2);
    chk("b2b_beats", beat_seen, 2);

    // Flush on beat 2 of 4 with two ops queued behind it
    clear_logs();
    push_op(4, 2, 5);
    push_op(8, 0, 6);
    push_op(9, 0, 7);
    wait_beat("flush_beat1");
    step();
    flush = 1'b1;
    agu_idle = 1'b0;
    #1;
    chk("flush_cycle_beat", int'(beat_valid), 0);
    chk("flush_cycle_last", int'(beat_last), 0);
    chk("flush_cycle_en", int'(agu_en), 0);
    chk("flush_cycle_err", int'(err_valid), 0);
    step();
    flush = 1'b0;
    chk("flush_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) agu_idle = 1'b1;
      #1;
      chk($sformatf("flush_quiet_beat%0d", k), int'(beat_valid), 0);
      chk($sformatf("flush_quiet_en%0d", k), int'(agu_en), 0);
      step();
    end
    chk("flush_no_last", last_tag_q.size(), 0);
    clear_logs();
    push_op(2, 1, 11);
    run(6);
    chk("flush_new_cnt", last_tag_q.size(), 1);
    if (last_tag_q.size() == 1) chk("flush_new_tag", last_tag_q[0], 11);
    chk("flush_new_beats", beat_seen, 2);

    // Asynchronous reset in the middle of a beat run
    clear_logs();
    push_op(16, 3, 12);
    wait_beat("rst_beat1");
    run(2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    run(2);
    rst = 1'b0;
    clear_logs();
    run(12);
    chk("rst_no_beats", beat_seen, 0);
    chk("rst_no_en", en_addr_q.size(), 0);
    push_op(1, 0, 13);
    run(5);
    chk("rst_new_cnt", last_tag_q.size(), 1);
    if (last_tag_q.size() == 1) chk("rst_new_tag", last_tag_q[0], 13);
    chk("rst_new_beats", beat_seen, 1);

    // Random traffic against the scoreboard
    clear_logs();
    exp_q.delete();
    pend = 0;
    sb_on = 1'b1;
    for (int k = 0; k < 600; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_vreg  = 5'($urandom_range(0, 31));
      in_vlmul = 3'($urandom_range(0, 7));
      in_tag   = 4'($urandom_range(0, 15));
      agu_idle = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    agu_idle = 1'b1;
    for (int k = 0; k < 300 && (exp_q.size() > 0 || pend > 0); k++) step();
    run(2);
    chk("rand_drained", exp_q.size() + pend, 0);
    chk("rand_activity", int'(en_addr_q.size() > 20 && err_tag_q.size() > 10), 1);
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
